// File: rtl/rram_addr_issuer.sv
// Nibble-serial address issuer for the RRAM address bus: selects the chip,
// shifts ADDR_W bits out MSB-nibble-first on WE rising edges under ALE, then holds CE low.
module rram_addr_issuer #(
    parameter int ADDR_W      = 12,
    parameter int NIB_W       = 4,
    parameter int SETUP_CYC   = 2,
    parameter int WE_LOW_CYC  = 2,
    parameter int WE_HIGH_CYC = 2,
    parameter int HOLD_CYC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              ce_release,
    output logic              busy,
    output logic              done,
    output logic [NIB_W-1:0]  IO,
    output logic              CE,
    output logic              WE,
    output logic              ALE
);
    localparam int NUM_NIB = ADDR_W / NIB_W;
    localparam int MAX_A   = (SETUP_CYC > WE_LOW_CYC) ? SETUP_CYC : WE_LOW_CYC;
    localparam int MAX_B   = (WE_HIGH_CYC > HOLD_CYC) ? WE_HIGH_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int NIB_IW  = $clog2(NUM_NIB) + 1;

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  WLO_LAST   = CNT_W'(WE_LOW_CYC - 1);
    localparam logic [CNT_W-1:0]  WHI_LAST   = CNT_W'(WE_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [NIB_IW-1:0] NIB_LAST   = NIB_IW'(NUM_NIB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_ALSU, S_WLO, S_WHI, S_AOFF, S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NIB_IW-1:0]   nib_q, nib_d;
    logic [ADDR_W-1:0]   shadow_q, shadow_d;
    logic                busy_d, done_d, ce_d, we_d, ale_d;
    logic [NIB_W-1:0]    io_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            nib_q    <= '0;
            shadow_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            IO       <= '0;
            CE       <= 1'b1;
            WE       <= 1'b1;
            ALE      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nib_q    <= nib_d;
            shadow_q <= shadow_d;
            busy     <= busy_d;
            done     <= done_d;
            IO       <= io_d;
            CE       <= ce_d;
            WE       <= we_d;
            ALE      <= ale_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        nib_d    = nib_q;
        shadow_d = shadow_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    shadow_d = addr_in;
                    nib_d    = '0;
                    state_d  = S_SEL;
                end
            end
            S_SEL: if (cnt_q == SETUP_LAST) begin
                cnt_d   = '0;
                state_d = S_ALSU;
            end
            S_ALSU: if (cnt_q == SETUP_LAST) begin
                cnt_d   = '0;
                state_d = S_WLO;
            end
            S_WLO: if (cnt_q == WLO_LAST) begin
                cnt_d   = '0;
                state_d = S_WHI;
            end
            S_WHI: if (cnt_q == WHI_LAST) begin
                cnt_d = '0;
                if (nib_q == NIB_LAST) begin
                    state_d = S_AOFF;
                end else begin
                    // Shifting the shadow puts the next nibble on top, so IO moves on WLO entry.
                    nib_d    = nib_q + 1'b1;
                    shadow_d = shadow_q << NIB_W;
                    state_d  = S_WLO;
                end
            end
            S_AOFF: if (cnt_q == HOLD_LAST) begin
                cnt_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                cnt_d = '0;
                if (start) begin
                    shadow_d = addr_in;
                    nib_d    = '0;
                    state_d  = S_ALSU;
                end else if (ce_release) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        ce_d   = (state_d == S_IDLE);
        ale_d  = (state_d == S_ALSU) || (state_d == S_WLO) || (state_d == S_WHI);
        we_d   = (state_d != S_WLO);
        busy_d = (state_d != S_IDLE) && (state_d != S_HOLD);
        done_d = (state_d == S_HOLD) && (state_q != S_HOLD);
        io_d   = '0;
        if (ale_d || state_d == S_AOFF)
            io_d = shadow_d[ADDR_W-1 -: NIB_W];
    end
endmodule
